// File: rtl/shift_cmd_seq_pkg.sv
// Shared types and widths for the shift-register command sequencer.
package shift_pkg;

  localparam int DW = 4;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_SHL  = 2'd2,
    OP_SHR  = 2'd3
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/shift_cmd_seq_if.sv
// Command handshake between an upstream controller (master) and the sequencer (slave).
interface shift_cmd_if;
  import shift_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  shift_op_e       cmd_op;
  logic [DW-1:0]   cmd_data;
  logic [CW-1:0]   cmd_amt;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_amt, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_amt, output cmd_ready);

endinterface

// File: rtl/shift_cmd_seq_step_counter.sv
// Loadable down-counter for single-step shift expansion; o_term flags the final step.
module step_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_term
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_term = (r_count == CW'(1));

endmodule

// File: rtl/shift_cmd_seq.sv
// Command sequencer driving the 4-bit shift register's d_in/s_cnt/sl/sr/ld controls.
// Optional build macro SHIFT_SEQ_BURST_EN: a shift of N issues one strobe with s_cnt=N.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready=1
// LOAD    | ld strobe cycle
// SHIFT   | sl/sr strobe cycle(s)
// DONE    | done pulse, cmd_ready=1 (next command may be accepted)
module shift_cmd_seq
  import shift_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  shift_cmd_if.slave    cmd,
  output logic [DW-1:0] o_d_in,
  output logic [CW-1:0] o_s_cnt,
  output logic          o_sl,
  output logic          o_sr,
  output logic          o_ld,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_LOAD  = 2'(ST_LOAD);
  localparam logic [1:0] S_SHIFT = 2'(ST_SHIFT);
  localparam logic [1:0] S_DONE  = 2'(ST_DONE);

  logic [1:0]    r_state;
  logic [1:0]    w_nxt;
  logic          r_ready;
  logic          r_left;
  logic          w_left;
  logic          w_accept;
  logic          w_shift_cmd;
  logic          w_last;
  logic [CW-1:0] w_s_cnt_nxt;

  assign w_accept    = cmd.cmd_valid && r_ready;
  assign w_shift_cmd = ((cmd.cmd_op == OP_SHL) || (cmd.cmd_op == OP_SHR)) && (cmd.cmd_amt != '0);
  assign w_left      = w_accept ? (cmd.cmd_op == OP_SHL) : r_left;
  assign cmd.cmd_ready = r_ready;

`ifdef SHIFT_SEQ_BURST_EN
  assign w_last = 1'b1;
`else
  step_counter #(.CW(CW)) u_step_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (cmd.cmd_amt),
    .i_dec      (r_state == S_SHIFT),
    .o_term     (w_last)
  );
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (cmd.cmd_op == OP_LOAD) w_nxt = S_LOAD;
          else if (w_shift_cmd)      w_nxt = S_SHIFT;
          else                       w_nxt = S_DONE;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      S_LOAD:  w_nxt = S_DONE;
      S_SHIFT: w_nxt = w_last ? S_DONE : S_SHIFT;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Only entry from an accepted command reaches SHIFT in burst mode, so cmd_amt is live here.
  always_comb begin
    w_s_cnt_nxt = '0;
    if (w_nxt == S_SHIFT) begin
`ifdef SHIFT_SEQ_BURST_EN
      w_s_cnt_nxt = cmd.cmd_amt;
`else
      w_s_cnt_nxt = CW'(1);
`endif
    end
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_left  <= 1'b0;
      o_d_in  <= '0;
      o_s_cnt <= '0;
      o_sl    <= 1'b0;
      o_sr    <= 1'b0;
      o_ld    <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ready <= (w_nxt == S_IDLE) || (w_nxt == S_DONE);
      r_left  <= w_left;
      if (w_accept && (cmd.cmd_op == OP_LOAD)) o_d_in <= cmd.cmd_data;
      o_s_cnt <= w_s_cnt_nxt;
      o_sl    <= (w_nxt == S_SHIFT) && w_left;
      o_sr    <= (w_nxt == S_SHIFT) && !w_left;
      o_ld    <= (w_nxt == S_LOAD);
      o_busy  <= (w_nxt == S_LOAD) || (w_nxt == S_SHIFT);
      o_done  <= (w_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Directed bench for shift_cmd_seq; follows SHIFT_SEQ_BURST_EN if defined for the build.
module tb_shift_cmd_seq;
  import shift_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] d_in;
  logic [CW-1:0] s_cnt;
  logic          sl, sr, ld, busy, done;
  int            checks = 0;
  int            errors = 0;

  shift_cmd_if ifc ();

  shift_cmd_seq dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (ifc),
    .o_d_in  (d_in),
    .o_s_cnt (s_cnt),
    .o_sl    (sl),
    .o_sr    (sr),
    .o_ld    (ld),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  // Observed vector: {ld, sl, sr, busy, done, cmd_ready, s_cnt, d_in}
  wire [13:0] obs = {ld, sl, sr, busy, done, ifc.cmd_ready, s_cnt, d_in};

  function automatic logic [13:0] mk(input logic l, input logic a, input logic b, input logic bz,
                                     input logic dn, input logic rd, input logic [3:0] sc,
                                     input logic [3:0] di);
    return {l, a, b, bz, dn, rd, sc, di};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one edge, then scrambles the fields to prove they were captured.
  task automatic issue(input shift_op_e op, input logic [3:0] data, input logic [3:0] amt);
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_data  = data;
    ifc.cmd_amt   = amt;
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = OP_LOAD;
    ifc.cmd_data  = ~data;
    ifc.cmd_amt   = 4'd9;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = mk(0,0,0,0,0,1,4'd0,4'd0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_state got=%b exp=%b", obs, e); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [13:0] e [3];
    e[0] = mk(1,0,0,1,0,0,4'd0,4'hA);
    e[1] = mk(0,0,0,0,1,1,4'd0,4'hA);
    e[2] = mk(0,0,0,0,0,1,4'd0,4'hA);
    issue(OP_LOAD, 4'hA, 4'd7);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL load T+%0d got=%b exp=%b", i+1, obs, e[i]); end
      if (i < 2) step();
    end
  endtask

  task automatic test_shl();
    logic [13:0] e [5];
    int n;
`ifdef SHIFT_SEQ_BURST_EN
    n = 3;
    e[0] = mk(0,1,0,1,0,0,4'd3,4'hA);
    e[1] = mk(0,0,0,0,1,1,4'd0,4'hA);
    e[2] = mk(0,0,0,0,0,1,4'd0,4'hA);
`else
    n = 5;
    e[0] = mk(0,1,0,1,0,0,4'd1,4'hA);
    e[1] = e[0];
    e[2] = e[0];
    e[3] = mk(0,0,0,0,1,1,4'd0,4'hA);
    e[4] = mk(0,0,0,0,0,1,4'd0,4'hA);
`endif
    issue(OP_SHL, 4'h0, 4'd3);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL shl3 T+%0d got=%b exp=%b", i+1, obs, e[i]); end
      if (i < n-1) step();
    end
  endtask

  task automatic test_zero_nop();
    logic [13:0] e_done, e_idle;
    e_done = mk(0,0,0,0,1,1,4'd0,4'hA);
    e_idle = mk(0,0,0,0,0,1,4'd0,4'hA);
    issue(OP_SHR, 4'h3, 4'd0);
    checks++;
    if (obs !== e_done) begin errors++; $display("FAIL shr0_done got=%b exp=%b", obs, e_done); end
    issue(OP_NOP, 4'h3, 4'd4);
    checks++;
    if (obs !== e_done) begin errors++; $display("FAIL nop_done got=%b exp=%b", obs, e_done); end
    step();
    checks++;
    if (obs !== e_idle) begin errors++; $display("FAIL nop_idle got=%b exp=%b", obs, e_idle); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] e;
    int          pulses;
    int          first_cnt;
    int          exp_pulses;
    int          exp_cnt;
    logic        seen_done;
`ifdef SHIFT_SEQ_BURST_EN
    exp_pulses = 1;
    exp_cnt    = 15;
    issue(OP_SHR, 4'h0, 4'd2);
    e = mk(0,0,1,1,0,0,4'd2,4'hA);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL shr2 T+1 got=%b exp=%b", obs, e); end
`else
    exp_pulses = 15;
    exp_cnt    = 1;
    issue(OP_SHR, 4'h0, 4'd2);
    e = mk(0,0,1,1,0,0,4'd1,4'hA);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== e) begin errors++; $display("FAIL shr2 T+%0d got=%b exp=%b", i+1, obs, e); end
      step();
    end
`endif
`ifdef SHIFT_SEQ_BURST_EN
    step();
`endif
    e = mk(0,0,0,0,1,1,4'd0,4'hA);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL shr2_done got=%b exp=%b", obs, e); end
    issue(OP_LOAD, 4'h5, 4'd0);
    e = mk(1,0,0,1,0,0,4'd0,4'h5);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL b2b_load got=%b exp=%b", obs, e); end
    step();
    e = mk(0,0,0,0,1,1,4'd0,4'h5);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL b2b_load_done got=%b exp=%b", obs, e); end
    issue(OP_SHR, 4'h0, 4'd15);
    pulses    = 0;
    first_cnt = -1;
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (sr) begin
        pulses++;
        if (first_cnt < 0) first_cnt = int'(s_cnt);
      end
      if (done) seen_done = 1'b1;
      else step();
    end
    checks++;
    if (!seen_done) begin errors++; $display("FAIL shr15_timeout got=no_done exp=done"); end
    checks++;
    if (pulses != exp_pulses) begin errors++; $display("FAIL shr15_pulses got=%0d exp=%0d", pulses, exp_pulses); end
    checks++;
    if (first_cnt != exp_cnt) begin errors++; $display("FAIL shr15_s_cnt got=%0d exp=%0d", first_cnt, exp_cnt); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
`ifdef SHIFT_SEQ_BURST_EN
    e = mk(0,1,0,1,0,0,4'd5,4'h5);
`else
    e = mk(0,1,0,1,0,0,4'd1,4'h5);
`endif
    issue(OP_SHL, 4'h0, 4'd5);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL rstmid T+1 got=%b exp=%b", obs, e); end
    step();
`ifndef SHIFT_SEQ_BURST_EN
    checks++;
    if (obs !== e) begin errors++; $display("FAIL rstmid T+2 got=%b exp=%b", obs, e); end
`endif
    #2;
    rst = 1'b1;
    #1;
    e = mk(0,0,0,0,0,1,4'd0,4'd0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL rstmid_async got=%b exp=%b", obs, e); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rstmid_after c%0d got=%b exp=%b", i, obs, e); end
    end
  endtask

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = OP_NOP;
    ifc.cmd_data  = '0;
    ifc.cmd_amt   = '0;
    test_reset();
    test_load();
    test_shl();
    test_zero_nop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_cmd_seq.md
Name: shift_cmd_seq

Overview:
Command sequencer that sits directly upstream of the 4-bit shift register and drives its d_in/s_cnt/sl/sr/ld controls.
- Accepts one command at a time over a valid/ready handshake: NOP, LOAD, shift-left-by-N or shift-right-by-N.
- Expands a shift command into N single-step shift cycles.
- Reports completion with a one-cycle done pulse.

Parameters:
DW, 4, data width of d_in and cmd_data; must match the shift register width.
CW, 4, width of cmd_amt and s_cnt.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
cmd_op  input  2  0=NOP, 1=LOAD, 2=SHL, 3=SHR.
cmd_data  input  DW  load value (LOAD only).
cmd_amt  input  CW  shift step count N (SHL/SHR only).
d_in  output  DW  to shift register: load data.
s_cnt  output  CW  to shift register: shift count for this cycle.
sl  output  1  to shift register: shift-left strobe.
sr  output  1  to shift register: shift-right strobe.
ld  output  1  to shift register: load strobe.
busy  output  1  command in progress.
done  output  1  one-cycle pulse when a command completes.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-command):
  - state=IDLE; d_in=0, s_cnt=0, sl=sr=ld=0, busy=0, done=0.
  - Step counter cleared; pending steps discarded.
- FSM states:
  - IDLE: cmd_ready=1.
  - LOAD: one cycle.
  - SHIFT: N cycles.
  - DONE: one cycle; cmd_ready=1.
- Accept: cmd_valid&&cmd_ready at edge T. Command fields are captured at T; later input changes are ignored.
- LOAD:
  - Cycle T+1: ld=1, d_in=cmd_data.
  - Cycle T+2: done=1.
- SHL/SHR with N>0:
  - Cycles T+1..T+N: sl (SHL) or sr (SHR) =1 and s_cnt=1.
  - Cycle T+N+1: done=1.
- SHL/SHR with N=0, and NOP:
  - No strobe, ever.
  - Cycle T+1: done=1.
- Strobe exclusivity: at most one of ld/sl/sr is high in any cycle. When no strobe is high, s_cnt=0. d_in holds its last loaded value.
- busy=1 in LOAD and SHIFT, 0 in IDLE and DONE.
- Back-to-back commands: DONE asserts cmd_ready.
  - A command accepted in DONE goes directly to LOAD/SHIFT/DONE.
  - This gives zero bubble between the done pulse and the next command's first strobe.
- Step counter: CW bits, loaded with N, decremented once per strobe cycle, exit SHIFT when it reaches 1. N=15 gives exactly 15 strobes (no wrap).
- cmd_valid while busy: ignored; no backpressure violation, and the command is held by the upstream until ready.

Optional Feature:
SHIFT_SEQ_BURST_EN
- Defined:
  - SHL/SHR with N>0 issue a single strobe cycle at T+1 with s_cnt=N; done at T+2.
  - SHIFT state lasts one cycle; the step counter is removed.
- Undefined: single-step expansion as above.
- Both builds keep identical NOP/LOAD timing and handshake rules.

Decomposition:
- Package shift_pkg holds:
  - op encoding typedef shift_op_e (OP_NOP, OP_LOAD, OP_SHL, OP_SHR);
  - FSM state typedef seq_state_e;
  - constants DW=4, CW=4.
- One natural sub-module: step_counter (loadable down-counter with terminal flag), instantiated only when SHIFT_SEQ_BURST_EN is undefined.

Test Plan:
- Reset mid-SHL: SHL N=5, assert rst after 2 strobes → outputs 0 immediately (async), no further sl, cmd_ready=1 after release.
- LOAD 4'hA → ld=1 with d_in=4'hA for exactly one cycle at T+1, done at T+2, busy high only at T+1.
- SHL N=3 → sl=1 and s_cnt=1 at T+1..T+3, sr=ld=0 throughout, done at T+4; cmd_ready=0 during T+1..T+3.
- SHR N=0 then NOP → no strobes; done at T+1 for each; second command accepted in DONE cycle.
- Back-to-back: LOAD 4'h5 accepted in DONE of SHR N=2 → ld the cycle after done; SHR N=15 → exactly 15 sr pulses.
  - With SHIFT_SEQ_BURST_EN: SHR N=15 → one sr cycle with s_cnt=15.
